// File: rtl/ampel_timer.sv
// Phase timer, second prescaler and pedestrian-button conditioning for the traffic-light controller.
// Define AMPEL_F_LATCH_EN to make the pedestrian requests sticky until cleared by *_f_clr.
module ampel_timer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned DEB_CYC  = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [4:0] init,
  output logic [4:0] count,
  output logic       ready,
  input  logic       hs_f_btn,
  input  logic       ns_f_btn,
  input  logic       hs_f_clr,
  input  logic       ns_f_clr,
  output logic       hs_f_an,
  output logic       ns_f_an
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEB_CYC + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYC - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    count_q, count_d;
  logic          ready_q, ready_d;
  logic [0:0]    state_q, state_d;
  logic          tick;

  assign tick = (presc_q == PRESC_MAX);

  // Load wins over a coincident tick, so a reload always suppresses a pending expiry.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    count_d = count_q;
    ready_d = 1'b0;
    state_d = state_q;
    if (load) begin
      count_d = init;
      presc_d = '0;
      if (init == 5'd0) begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_RUN;
      end
    end else if (tick && (state_q == ST_RUN)) begin
      count_d = count_q - 5'd1;
      if (count_q == 5'd1) begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      ready_q <= ready_d;
      state_q <= state_d;
    end
  end

  assign count = count_q;
  assign ready = ready_q;

  logic [1:0] btn_raw;
  logic [1:0] f_clr;
  logic [1:0] f_an;

  assign btn_raw = {ns_f_btn, hs_f_btn};
  assign f_clr   = {ns_f_clr, hs_f_clr};
  assign hs_f_an = f_an[0];
  assign ns_f_an = f_an[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          lvl_q, lvl_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // The level flips on the edge where the counter would reach DEB_CYC.
    always_comb begin
      sync1_d = btn_raw[ch];
      sync2_d = sync1_q;
      lvl_d   = lvl_q;
      cnt_d   = '0;
      if (sync2_q != lvl_q) begin
        if (cnt_q == DEB_MAX) begin
          lvl_d = ~lvl_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        lvl_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        lvl_q   <= lvl_d;
        cnt_q   <= cnt_d;
      end
    end

`ifdef AMPEL_F_LATCH_EN
    logic an_q, an_d;

    // Set tracks lvl_d so the request rises on the same edge as the debounced level; set beats clear.
    always_comb begin
      an_d = an_q;
      if (lvl_d && !lvl_q) begin
        an_d = 1'b1;
      end else if (f_clr[ch]) begin
        an_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        an_q <= 1'b0;
      end else begin
        an_q <= an_d;
      end
    end

    assign f_an[ch] = an_q;
`else
    logic unused_clr;
    assign unused_clr = f_clr[ch];
    assign f_an[ch]   = lvl_q;
`endif
  end

endmodule

// File: tb/tb_ampel_timer.sv
// Scoreboard bench for ampel_timer (TICK_DIV=4, DEB_CYC=5): stimulus queues expected values per cycle,
// a negedge monitor pops and compares them, and every ready pulse is matched against an expected-cycle queue.
module tb_ampel_timer;

  localparam int SIG_COUNT = 0;
  localparam int SIG_READY = 1;
  localparam int SIG_HS    = 2;
  localparam int SIG_NS    = 3;

  logic       clk;
  logic       reset_n;
  logic       load;
  logic [4:0] init;
  logic [4:0] count;
  logic       ready;
  logic       hs_f_btn;
  logic       ns_f_btn;
  logic       hs_f_clr;
  logic       ns_f_clr;
  logic       hs_f_an;
  logic       ns_f_an;

  ampel_timer #(
    .TICK_DIV(4),
    .DEB_CYC (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .init    (init),
    .count   (count),
    .ready   (ready),
    .hs_f_btn(hs_f_btn),
    .ns_f_btn(ns_f_btn),
    .hs_f_clr(hs_f_clr),
    .ns_f_clr(ns_f_clr),
    .hs_f_an (hs_f_an),
    .ns_f_an (ns_f_an)
  );

  typedef struct {
    string name;
    int    cyc;
    int    sig;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   rdy_q[$];
  int   cyc = 0;
  int   checks_total = 0;
  int   checks_passed = 0;
  exp_t mon_e;
  int   mon_act;
  int   mon_r;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input string name, input int c, input int sig, input int val);
    exp_t e;
    e.name = name;
    e.cyc  = c;
    e.sig  = sig;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation due this cycle, and account for every ready pulse seen.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      checks_total++;
      case (mon_e.sig)
        SIG_COUNT: mon_act = int'(count);
        SIG_READY: mon_act = int'(ready);
        SIG_HS:    mon_act = int'(hs_f_an);
        default:   mon_act = int'(ns_f_an);
      endcase
      if (mon_e.cyc != cyc) begin
        $display("[TB] FAIL %s: sampled at cycle %0d, due at cycle %0d", mon_e.name, cyc, mon_e.cyc);
      end else if (mon_act != mon_e.val) begin
        $display("[TB] FAIL %s @cyc %0d: got %0d, expected %0d", mon_e.name, cyc, mon_act, mon_e.val);
      end else begin
        checks_passed++;
      end
    end
    if (ready === 1'b1) begin
      checks_total++;
      if (rdy_q.size() == 0) begin
        $display("[TB] FAIL ready_pulse @cyc %0d: got unexpected pulse, expected none", cyc);
      end else begin
        mon_r = rdy_q.pop_front();
        if (mon_r != cyc) begin
          $display("[TB] FAIL ready_pulse: got pulse at cycle %0d, expected cycle %0d", cyc, mon_r);
        end else begin
          checks_passed++;
        end
      end
    end
  end

  task automatic test_countdown();
    int l;
    l = cyc + 1;
    load = 1'b1;
    init = 5'd3;
    push_exp("cd_load", l, SIG_COUNT, 3);
    push_exp("cd_load_rdy", l, SIG_READY, 0);
    push_exp("cd_2", l + 4, SIG_COUNT, 2);
    push_exp("cd_1", l + 8, SIG_COUNT, 1);
    push_exp("cd_0", l + 12, SIG_COUNT, 0);
    push_exp("cd_rdy", l + 12, SIG_READY, 1);
    push_exp("cd_rdy_drop", l + 13, SIG_READY, 0);
    push_exp("cd_idle_hold", l + 16, SIG_COUNT, 0);
    rdy_q.push_back(l + 12);
    wait_edges(1);
    load = 1'b0;
    wait_edges(16);
  endtask

  task automatic test_zero_load();
    int l;
    l = cyc + 1;
    load = 1'b1;
    init = 5'd0;
    push_exp("zero_rdy", l, SIG_READY, 1);
    push_exp("zero_count", l, SIG_COUNT, 0);
    push_exp("zero_rdy_drop", l + 1, SIG_READY, 0);
    rdy_q.push_back(l);
    wait_edges(1);
    load = 1'b0;
    wait_edges(1);
  endtask

  task automatic test_priority();
    int l;
    int l2;
    l = cyc + 1;
    load = 1'b1;
    init = 5'd2;
    push_exp("prio_load", l, SIG_COUNT, 2);
    push_exp("prio_1", l + 4, SIG_COUNT, 1);
    wait_edges(1);
    load = 1'b0;
    wait_edges(7);
    l2 = l + 8;
    load = 1'b1;
    init = 5'd5;
    push_exp("prio_reload", l2, SIG_COUNT, 5);
    push_exp("prio_no_rdy", l2, SIG_READY, 0);
    push_exp("prio_4", l2 + 4, SIG_COUNT, 4);
    push_exp("prio_end", l2 + 20, SIG_COUNT, 0);
    push_exp("prio_end_rdy", l2 + 20, SIG_READY, 1);
    rdy_q.push_back(l2 + 20);
    wait_edges(1);
    load = 1'b0;
    wait_edges(20);
  endtask

  task automatic test_restart();
    int l;
    int r;
    l = cyc + 1;
    load = 1'b1;
    init = 5'd3;
    push_exp("rst_load", l, SIG_COUNT, 3);
    push_exp("rst_2", l + 4, SIG_COUNT, 2);
    wait_edges(1);
    load = 1'b0;
    wait_edges(6);
    r = l + 7;
    load = 1'b1;
    init = 5'd2;
    push_exp("restart_load", r, SIG_COUNT, 2);
    push_exp("restart_1", r + 4, SIG_COUNT, 1);
    push_exp("restart_0", r + 8, SIG_COUNT, 0);
    push_exp("restart_rdy", r + 8, SIG_READY, 1);
    rdy_q.push_back(r + 8);
    wait_edges(1);
    load = 1'b0;
    wait_edges(8);
  endtask

  task automatic test_reset();
    int l;
    l = cyc + 1;
    load = 1'b1;
    init = 5'd9;
    push_exp("mid_load", l, SIG_COUNT, 9);
    push_exp("mid_7", l + 8, SIG_COUNT, 7);
    wait_edges(1);
    load = 1'b0;
    wait_edges(9);
    reset_n = 1'b0;
    push_exp("async_count", l + 9, SIG_COUNT, 0);
    push_exp("async_ready", l + 9, SIG_READY, 0);
    push_exp("async_hs", l + 9, SIG_HS, 0);
    push_exp("async_ns", l + 9, SIG_NS, 0);
    wait_edges(2);
    reset_n = 1'b1;
    push_exp("post_reset_idle", l + 40, SIG_COUNT, 0);
    wait_edges(30);
  endtask

  task automatic test_hs_debounce();
    int k;
    int kr;
    k = cyc + 1;
    hs_f_btn = 1'b1;
    push_exp("glitch_hs_a", k + 6, SIG_HS, 0);
    push_exp("glitch_hs_b", k + 9, SIG_HS, 0);
    wait_edges(3);
    hs_f_btn = 1'b0;
    wait_edges(10);
    k = cyc + 1;
    hs_f_btn = 1'b1;
    push_exp("press_hs_before", k + 5, SIG_HS, 0);
    push_exp("press_hs_rise", k + 6, SIG_HS, 1);
    wait_edges(10);
    hs_f_btn = 1'b0;
    kr = k + 10;
    push_exp("release_hs_hold", kr + 5, SIG_HS, 1);
`ifdef AMPEL_F_LATCH_EN
    push_exp("latch_hs_hold", kr + 6, SIG_HS, 1);
    push_exp("latch_hs_hold2", kr + 10, SIG_HS, 1);
`else
    push_exp("release_hs_fall", kr + 6, SIG_HS, 0);
`endif
    wait_edges(11);
    hs_f_clr = 1'b1;
    push_exp("clr_hs", kr + 11, SIG_HS, 0);
    wait_edges(1);
    hs_f_clr = 1'b0;
  endtask

  task automatic test_ns_latch();
    int k;
    k = cyc + 1;
    ns_f_btn = 1'b1;
    push_exp("press_ns_rise", k + 6, SIG_NS, 1);
    wait_edges(10);
    ns_f_btn = 1'b0;
`ifdef AMPEL_F_LATCH_EN
    push_exp("latch_ns_hold", k + 16, SIG_NS, 1);
    push_exp("latch_ns_hold2", k + 20, SIG_NS, 1);
`else
    push_exp("release_ns_fall", k + 16, SIG_NS, 0);
    push_exp("release_ns_low", k + 20, SIG_NS, 0);
`endif
    wait_edges(11);
    ns_f_clr = 1'b1;
    push_exp("clr_ns", k + 21, SIG_NS, 0);
    wait_edges(1);
    ns_f_clr = 1'b0;
    k = cyc + 1;
    ns_f_btn = 1'b1;
    push_exp("setclr_ns_before", k + 5, SIG_NS, 0);
    push_exp("setclr_ns_rise", k + 6, SIG_NS, 1);
    push_exp("setclr_ns_hold", k + 8, SIG_NS, 1);
    wait_edges(6);
    ns_f_clr = 1'b1;
    wait_edges(1);
    ns_f_clr = 1'b0;
    wait_edges(3);
    ns_f_btn = 1'b0;
`ifdef AMPEL_F_LATCH_EN
    push_exp("setclr_ns_sticky", k + 20, SIG_NS, 1);
`else
    push_exp("setclr_ns_fall", k + 16, SIG_NS, 0);
`endif
    wait_edges(12);
  endtask

  initial begin
    reset_n  = 1'b0;
    load     = 1'b0;
    init     = 5'd0;
    hs_f_btn = 1'b0;
    ns_f_btn = 1'b0;
    hs_f_clr = 1'b0;
    ns_f_clr = 1'b0;
    push_exp("reset_count", 2, SIG_COUNT, 0);
    push_exp("reset_ready", 2, SIG_READY, 0);
    push_exp("reset_hs", 2, SIG_HS, 0);
    push_exp("reset_ns", 2, SIG_NS, 0);
    wait_edges(3);
    reset_n = 1'b1;
    wait_edges(2);

    test_countdown();
    test_zero_load();
    test_priority();
    test_restart();
    test_reset();
    test_hs_debounce();
    test_ns_latch();

    wait_edges(5);
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks_total++;
      $display("[TB] FAIL %s: got no sample, expected check at cycle %0d", mon_e.name, mon_e.cyc);
    end
    while (rdy_q.size() > 0) begin
      mon_r = rdy_q.pop_front();
      checks_total++;
      $display("[TB] FAIL ready_pulse: got no pulse, expected one at cycle %0d", mon_r);
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
